// File: rtl/lms_pkg.sv
// Shared definitions for the LMS input pair joiner: FSM states, sideband
// layout and the placement of main/aux samples inside a paired beat.
package lms_pkg;

  typedef enum logic [1:0] {
    ALIGN     = 2'd0,
    DROP_AUX  = 2'd1,
    DROP_MAIN = 2'd2
  } lms_state_t;

  // timestamp + has_time + length + eov + eob
  localparam int SIDEBAND_W = 64 + 1 + 16 + 1 + 1;

  typedef struct packed {
    logic [63:0] ts;
    logic        has_time;
    logic [15:0] length;
    logic        eov;
    logic        eob;
  } lms_sb_t;

  // Slot index of each stream inside the paired tdata (slot * ITEM_W = LSB)
  localparam int PAIR_MAIN_IDX = 0;
  localparam int PAIR_AUX_IDX  = 1;

  function automatic int pair_lsb(input int idx, input int item_w);
    return idx * item_w;
  endfunction

endpackage

// File: rtl/lms_pair_skid.sv
// Two-entry AXIS skid buffer. The space flag is registered so the upstream
// join logic never sees a combinational path from the downstream tready.
module lms_pair_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_space,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wp, r_rp, r_space;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;
  logic              w_push, w_pop;

  assign w_push    = i_valid & r_space;
  assign w_pop     = (r_cnt != 2'd0) & i_ready;
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  // Storage, pointers and fill level; space is precomputed from next fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
      r_space  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt   <= w_cnt_nxt;
      r_space <= (w_cnt_nxt != 2'd2);
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_valid = (r_cnt != 2'd0);
  assign o_space = r_space;

endmodule

// File: rtl/lms_input_pair_joiner.sv
// Joins one main (x[n]) beat and one aux (d[n]) beat into a paired beat for
// the LMS core. On a tlast mismatch the output packet is closed, the lagging
// stream is drained up to its own tlast, and the event is counted.
module lms_input_pair_joiner
  import lms_pkg::*;
#(
  parameter int ITEM_W    = 32,
  parameter int ERR_CNT_W = 16
) (
  input  logic                  ce_clk,
  input  logic                  ce_rst_n,
  input  logic                  enable,
  input  logic                  err_clr,
  input  logic [ITEM_W-1:0]     s_main_tdata,
  input  logic                  s_main_tlast,
  input  logic                  s_main_tvalid,
  output logic                  s_main_tready,
  input  logic [63:0]           s_main_ttimestamp,
  input  logic                  s_main_thas_time,
  input  logic [15:0]           s_main_tlength,
  input  logic                  s_main_teov,
  input  logic                  s_main_teob,
  input  logic [ITEM_W-1:0]     s_aux_tdata,
  input  logic                  s_aux_tlast,
  input  logic                  s_aux_tvalid,
  output logic                  s_aux_tready,
  output logic [2*ITEM_W-1:0]   m_pair_tdata,
  output logic                  m_pair_tlast,
  output logic                  m_pair_tvalid,
  input  logic                  m_pair_tready,
  output logic [63:0]           m_pair_ttimestamp,
  output logic                  m_pair_thas_time,
  output logic [15:0]           m_pair_tlength,
  output logic                  m_pair_teov,
  output logic                  m_pair_teob,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [1:0]            state_o
);

  localparam int MAIN_LSB = pair_lsb(PAIR_MAIN_IDX, ITEM_W);
  localparam int AUX_LSB  = pair_lsb(PAIR_AUX_IDX, ITEM_W);
  localparam int SKID_W   = 2*ITEM_W + 1 + SIDEBAND_W;

  lms_state_t             r_state, w_state_nxt;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic                   w_take, w_inc, w_in_tlast, w_space;
  logic [2*ITEM_W-1:0]    w_pair;
  lms_sb_t                w_sb, w_out_sb;
  logic [SKID_W-1:0]      w_skid_in, w_skid_out;

  assign w_pair[MAIN_LSB +: ITEM_W] = s_main_tdata;
  assign w_pair[AUX_LSB  +: ITEM_W] = s_aux_tdata;

  assign w_sb.ts       = s_main_ttimestamp;
  assign w_sb.has_time = s_main_thas_time;
  assign w_sb.length   = s_main_tlength;
  assign w_sb.eov      = s_main_teov;
  assign w_sb.eob      = s_main_teob;

  // State register; holds while enable is low because no beat is accepted
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) r_state <= ALIGN;
    else           r_state <= w_state_nxt;
  end

  // Join / drop decisions, input readies and next state
  always_comb begin
    w_state_nxt   = r_state;
    s_main_tready = 1'b0;
    s_aux_tready  = 1'b0;
    w_take        = 1'b0;
    w_inc         = 1'b0;
    w_in_tlast    = s_main_tlast;
    case (r_state)
      ALIGN: begin
        w_take        = enable & s_main_tvalid & s_aux_tvalid & w_space;
        s_main_tready = w_take;
        s_aux_tready  = w_take;
        if (w_take && (s_main_tlast != s_aux_tlast)) begin
          // close the output packet on whichever stream ended first
          w_inc       = 1'b1;
          w_in_tlast  = 1'b1;
          w_state_nxt = s_main_tlast ? DROP_AUX : DROP_MAIN;
        end
      end
      DROP_AUX: begin
        s_aux_tready = enable;
        if (enable && s_aux_tvalid && s_aux_tlast) w_state_nxt = ALIGN;
      end
      DROP_MAIN: begin
        s_main_tready = enable;
        if (enable && s_main_tvalid && s_main_tlast) w_state_nxt = ALIGN;
      end
      default: w_state_nxt = ALIGN;
    endcase
  end

  // Saturating misalignment counter; a clear beats a same-cycle increment
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n)                        r_err_cnt <= '0;
    else if (err_clr)                     r_err_cnt <= '0;
    else if (w_inc && (r_err_cnt != '1))  r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign w_skid_in = {w_pair, w_in_tlast, w_sb};

  lms_pair_skid #(.DATA_W(SKID_W)) u_skid (
    .clk     (ce_clk),
    .rst_n   (ce_rst_n),
    .i_data  (w_skid_in),
    .i_valid (w_take),
    .o_space (w_space),
    .o_data  (w_skid_out),
    .o_valid (m_pair_tvalid),
    .i_ready (m_pair_tready)
  );

  assign {m_pair_tdata, m_pair_tlast, w_out_sb} = w_skid_out;
  assign m_pair_ttimestamp = w_out_sb.ts;
  assign m_pair_thas_time  = w_out_sb.has_time;
  assign m_pair_tlength    = w_out_sb.length;
  assign m_pair_teov       = w_out_sb.eov;
  assign m_pair_teob       = w_out_sb.eob;

  assign err_cnt = r_err_cnt;
  assign state_o = r_state;

endmodule

// File: tb/tb_lms_input_pair_joiner.sv
// Scoreboard bench for lms_input_pair_joiner: a stream-level reference builds
// the expected paired output from the beat lists, drivers feed the inputs and
// a monitor pops and compares every output handshake.
module tb_lms_input_pair_joiner;

  localparam int IW    = 32;
  localparam int ERR_W = 8;

  typedef struct {
    logic [IW-1:0] d;
    logic          last;
    logic [63:0]   ts;
    logic          ht;
    logic [15:0]   len;
    logic          eov;
    logic          eob;
  } beat_t;

  typedef struct {
    logic [2*IW-1:0] d;
    logic            last;
    logic [63:0]     ts;
    logic            ht;
    logic [15:0]     len;
    logic            eov;
    logic            eob;
  } exp_t;

  logic ce_clk = 1'b0, ce_rst_n = 1'b0, enable = 1'b0, err_clr = 1'b0;
  logic [IW-1:0] s_main_tdata = '0, s_aux_tdata = '0;
  logic s_main_tlast = 0, s_main_tvalid = 0, s_aux_tlast = 0, s_aux_tvalid = 0;
  logic s_main_tready, s_aux_tready;
  logic [63:0] s_main_ttimestamp = '0;
  logic s_main_thas_time = 0, s_main_teov = 0, s_main_teob = 0;
  logic [15:0] s_main_tlength = '0;
  logic [2*IW-1:0] m_pair_tdata;
  logic m_pair_tlast, m_pair_tvalid, m_pair_thas_time, m_pair_teov, m_pair_teob;
  logic m_pair_tready = 0;
  logic [63:0] m_pair_ttimestamp;
  logic [15:0] m_pair_tlength;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0] state_o;

  int n_checks = 0, n_errs = 0;
  int rdy_pct = 100;
  beat_t mq[$], aq[$];
  exp_t  eq[$];

  always #5 ce_clk = ~ce_clk;

  lms_input_pair_joiner #(.ITEM_W(IW), .ERR_CNT_W(ERR_W)) dut (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n), .enable(enable), .err_clr(err_clr),
    .s_main_tdata(s_main_tdata), .s_main_tlast(s_main_tlast),
    .s_main_tvalid(s_main_tvalid), .s_main_tready(s_main_tready),
    .s_main_ttimestamp(s_main_ttimestamp), .s_main_thas_time(s_main_thas_time),
    .s_main_tlength(s_main_tlength), .s_main_teov(s_main_teov),
    .s_main_teob(s_main_teob),
    .s_aux_tdata(s_aux_tdata), .s_aux_tlast(s_aux_tlast),
    .s_aux_tvalid(s_aux_tvalid), .s_aux_tready(s_aux_tready),
    .m_pair_tdata(m_pair_tdata), .m_pair_tlast(m_pair_tlast),
    .m_pair_tvalid(m_pair_tvalid), .m_pair_tready(m_pair_tready),
    .m_pair_ttimestamp(m_pair_ttimestamp), .m_pair_thas_time(m_pair_thas_time),
    .m_pair_tlength(m_pair_tlength), .m_pair_teov(m_pair_teov),
    .m_pair_teob(m_pair_teob),
    .err_cnt(err_cnt), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk_main(input int k, input bit last);
    beat_t b;
    b.d = 32'h1000_0000 + k; b.last = last;
    b.ts = {32'hA5A5_0000 + k, 32'h0000_0000 + k * 3};
    b.ht = k[0]; b.len = 16'(k + 7); b.eov = last; b.eob = k[1];
    return b;
  endfunction

  function automatic beat_t mk_aux(input int k, input bit last);
    beat_t b;
    b.d = 32'hA000_0000 + k * 5; b.last = last;
    b.ts = 64'hDEAD_BEEF_0000_0000; b.ht = 1; b.len = 16'hFFFF; b.eov = 1; b.eob = 1;
    return b;
  endfunction

  // Stream-level reference of the joiner: pairs beats, closes on mismatch,
  // drops the lagging stream up to its tlast. Returns the misalignment count.
  task automatic build_exp(output int n_err);
    int i = 0, j = 0, st = 0;
    exp_t e;
    n_err = 0;
    while (i < mq.size() || j < aq.size()) begin
      if (st == 0) begin
        if (i >= mq.size() || j >= aq.size()) break;
        e.d = {aq[j].d, mq[i].d}; e.last = mq[i].last | aq[j].last;
        e.ts = mq[i].ts; e.ht = mq[i].ht; e.len = mq[i].len;
        e.eov = mq[i].eov; e.eob = mq[i].eob;
        eq.push_back(e);
        if (mq[i].last != aq[j].last) begin n_err++; st = mq[i].last ? 1 : 2; end
        i++; j++;
      end else if (st == 1) begin
        if (j >= aq.size()) break;
        if (aq[j].last) st = 0;
        j++;
      end else begin
        if (i >= mq.size()) break;
        if (mq[i].last) st = 0;
        i++;
      end
    end
  endtask

  task automatic put_main(input beat_t b);
    s_main_tdata = b.d; s_main_tlast = b.last; s_main_ttimestamp = b.ts;
    s_main_thas_time = b.ht; s_main_tlength = b.len;
    s_main_teov = b.eov; s_main_teob = b.eob;
  endtask

  task automatic put_aux(input beat_t b);
    s_aux_tdata = b.d; s_aux_tlast = b.last;
  endtask

  task automatic drive_main(input int vpct);
    int budget = 20000;
    bit hold = 0;
    while (1) begin
      @(negedge ce_clk);
      if (mq.size() == 0) begin s_main_tvalid = 0; break; end
      budget--;
      n_checks++;
      assert (budget > 0) else begin
        n_errs++; $error("FAIL main_drv_timeout: observed=%0d left expected=0", mq.size());
        mq.delete(); s_main_tvalid = 0; break;
      end
      n_checks--;
      if (!hold) s_main_tvalid = ($urandom_range(99) < vpct);
      put_main(mq[0]);
      #4;
      if (s_main_tvalid && s_main_tready) begin void'(mq.pop_front()); hold = 0; end
      else hold = s_main_tvalid;
    end
  endtask

  task automatic drive_aux(input int vpct);
    int budget = 20000;
    bit hold = 0;
    while (1) begin
      @(negedge ce_clk);
      if (aq.size() == 0) begin s_aux_tvalid = 0; break; end
      budget--;
      n_checks++;
      assert (budget > 0) else begin
        n_errs++; $error("FAIL aux_drv_timeout: observed=%0d left expected=0", aq.size());
        aq.delete(); s_aux_tvalid = 0; break;
      end
      n_checks--;
      if (!hold) s_aux_tvalid = ($urandom_range(99) < vpct);
      put_aux(aq[0]);
      #4;
      if (s_aux_tvalid && s_aux_tready) begin void'(aq.pop_front()); hold = 0; end
      else hold = s_aux_tvalid;
    end
  endtask

  task automatic wait_drain(input string tag);
    int budget = 5000;
    while (eq.size() != 0 && budget > 0) begin @(negedge ce_clk); budget--; end
    @(negedge ce_clk); #4;
    chk(tag, eq.size(), 0);
  endtask

  // Output monitor: randomised tready, stability under stall, scoreboard pop
  initial begin : monitor
    logic [2*IW-1:0] h_d; logic h_l; logic [63:0] h_ts;
    bit stalled = 0;
    exp_t e;
    h_d = '0; h_l = 0; h_ts = '0;
    while (1) begin
      @(negedge ce_clk);
      m_pair_tready = ($urandom_range(99) < rdy_pct);
      #4;
      if (!m_pair_tvalid) stalled = 0;
      else begin
        if (stalled) begin
          chk("stall_tdata", m_pair_tdata, h_d);
          chk("stall_tlast", m_pair_tlast, h_l);
          chk("stall_ts", m_pair_ttimestamp, h_ts);
        end
        if (m_pair_tready) begin
          stalled = 0;
          n_checks++;
          assert (eq.size() != 0) else begin
            n_errs++; $error("FAIL unexpected_beat: observed=%0h expected=none", m_pair_tdata);
          end
          if (eq.size() != 0) begin
            e = eq.pop_front();
            chk("pair_tdata", m_pair_tdata, e.d);
            chk("pair_tlast", m_pair_tlast, e.last);
            chk("pair_ts", m_pair_ttimestamp, e.ts);
            chk("pair_sb", {m_pair_thas_time, m_pair_tlength, m_pair_teov, m_pair_teob},
                {e.ht, e.len, e.eov, e.eob});
          end
        end else begin
          stalled = 1; h_d = m_pair_tdata; h_l = m_pair_tlast; h_ts = m_pair_ttimestamp;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ne, exp_err, npairs, len;
    beat_t bm, ba0, ba1;
    exp_err = 0;

    // Reset: valids and enable high, readies must still be low
    enable = 1; s_main_tvalid = 1; s_aux_tvalid = 1;
    repeat (3) @(posedge ce_clk);
    #1;
    chk("rst_main_rdy", s_main_tready, 0);
    chk("rst_aux_rdy", s_aux_tready, 0);
    chk("rst_tvalid", m_pair_tvalid, 0);
    chk("rst_tdata", m_pair_tdata, 0);
    chk("rst_side", {m_pair_tlast, m_pair_ttimestamp, m_pair_thas_time, m_pair_tlength,
                     m_pair_teov, m_pair_teob}, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_state", state_o, 0);
    @(negedge ce_clk);
    s_main_tvalid = 0; s_aux_tvalid = 0; ce_rst_n = 1;
    repeat (2) @(negedge ce_clk);

    // 1: aligned 8-beat packet, full rate, 1-cycle latency
    rdy_pct = 100;
    for (int k = 0; k < 8; k++) begin mq.push_back(mk_main(k, k == 7)); aq.push_back(mk_aux(k, k == 7)); end
    build_exp(ne); exp_err += ne;
    fork
      drive_main(100);
      drive_aux(100);
      begin
        @(negedge ce_clk); #4;
        chk("t1_take", {s_main_tready, s_aux_tready}, 2'b11);
        chk("t1_lat_pre", m_pair_tvalid, 0);
        @(posedge ce_clk); #1;
        chk("t1_lat_post", m_pair_tvalid, 1);
        chk("t1_beat0", m_pair_tdata, {32'hA000_0000, 32'h1000_0000});
      end
    join
    wait_drain("t1_drain");
    chk("t1_err", err_cnt, 0);

    // 2: main ends at beat 4, aux at beat 6; next packet aligned
    for (int k = 0; k < 5; k++) mq.push_back(mk_main(100 + k, k == 4));
    for (int k = 0; k < 7; k++) aq.push_back(mk_aux(100 + k, k == 6));
    for (int k = 0; k < 4; k++) begin mq.push_back(mk_main(200 + k, k == 3)); aq.push_back(mk_aux(200 + k, k == 3)); end
    build_exp(ne); exp_err += ne;
    fork drive_main(100); drive_aux(100); join
    wait_drain("t2_drain");
    chk("t2_err", err_cnt, 1);
    chk("t2_state", state_o, 0);

    // 3: random valids and tready over >= 1000 aligned pairs
    rdy_pct = 50; npairs = 0;
    while (npairs < 1000) begin
      len = $urandom_range(1, 16);
      for (int k = 0; k < len; k++) begin
        mq.push_back(mk_main(1000 + npairs + k, k == len - 1));
        aq.push_back(mk_aux(1000 + npairs + k, k == len - 1));
      end
      npairs += len;
    end
    build_exp(ne); exp_err += ne;
    fork drive_main(60); drive_aux(60); join
    wait_drain("t3_drain");
    chk("t3_err", err_cnt, exp_err);

    // 4: reset while in DROP_MAIN with both skid entries occupied
    rdy_pct = 0;
    repeat (2) @(negedge ce_clk);
    mq.push_back(mk_main(300, 0)); mq.push_back(mk_main(301, 0)); mq.push_back(mk_main(302, 0));
    aq.push_back(mk_aux(300, 0));  aq.push_back(mk_aux(301, 1));
    build_exp(ne);
    fork drive_main(100); drive_aux(100); join
    #4;
    chk("t4_state_pre", state_o, 2);
    chk("t4_full", m_pair_tvalid, 1);
    chk("t4_err_pre", err_cnt, exp_err + 1);
    @(posedge ce_clk); #2;
    ce_rst_n = 0;
    #1;
    chk("t4_rst_tvalid", m_pair_tvalid, 0);
    chk("t4_rst_state", state_o, 0);
    chk("t4_rst_err", err_cnt, 0);
    eq.delete(); exp_err = 0;
    @(negedge ce_clk); ce_rst_n = 1;
    rdy_pct = 100;
    repeat (3) @(negedge ce_clk);
    #4;
    chk("t4_empty", m_pair_tvalid, 0);

    // 5: saturate the counter, then clear on a mismatch cycle
    for (int k = 0; k < 254; k++) begin
      mq.push_back(mk_main(400 + k, 1));
      aq.push_back(mk_aux(400 + k, 0)); aq.push_back(mk_aux(700 + k, 1));
    end
    build_exp(ne);
    fork drive_main(100); drive_aux(100); join
    wait_drain("t5_drain_a");
    chk("t5_err_fe", err_cnt, 8'hFE);
    for (int k = 0; k < 3; k++) begin
      mq.push_back(mk_main(950 + k, 1));
      aq.push_back(mk_aux(950 + k, 0)); aq.push_back(mk_aux(960 + k, 1));
    end
    build_exp(ne);
    fork drive_main(100); drive_aux(100); join
    wait_drain("t5_drain_b");
    chk("t5_err_sat", err_cnt, 8'hFF);
    bm = mk_main(970, 1); ba0 = mk_aux(970, 0); ba1 = mk_aux(971, 1);
    mq.push_back(bm); aq.push_back(ba0); aq.push_back(ba1);
    build_exp(ne);
    mq.delete(); aq.delete();
    @(negedge ce_clk);
    put_main(bm); put_aux(ba0); s_main_tvalid = 1; s_aux_tvalid = 1; err_clr = 1;
    #4;
    chk("t5_clr_take", {s_main_tready, s_aux_tready}, 2'b11);
    @(posedge ce_clk); #1;
    err_clr = 0; s_main_tvalid = 0; put_aux(ba1);
    chk("t5_clr_err", err_cnt, 0);
    chk("t5_clr_state", state_o, 1);
    @(negedge ce_clk); #4;
    chk("t5_drop_rdy", {s_main_tready, s_aux_tready}, 2'b01);
    @(posedge ce_clk); #1;
    s_aux_tvalid = 0;
    chk("t5_realign", state_o, 0);
    wait_drain("t5_drain_c");
    chk("t5_err_final", err_cnt, 0);

    // 6: enable low with both inputs valid; skid drains, then resumes
    rdy_pct = 0;
    for (int k = 0; k < 6; k++) begin mq.push_back(mk_main(500 + k, k == 5)); aq.push_back(mk_aux(500 + k, k == 5)); end
    build_exp(ne);
    fork
      drive_main(100);
      drive_aux(100);
      begin
        repeat (6) @(posedge ce_clk);
        @(negedge ce_clk); enable = 0;
        #4;
        chk("t6_dis_rdy", {s_main_tready, s_aux_tready}, 2'b00);
        chk("t6_full", m_pair_tvalid, 1);
        rdy_pct = 100;
        repeat (4) @(negedge ce_clk);
        #4;
        chk("t6_drained", m_pair_tvalid, 0);
        chk("t6_dis_rdy2", {s_main_tready, s_aux_tready}, 2'b00);
        chk("t6_pending", eq.size(), 4);
        @(negedge ce_clk); enable = 1;
      end
    join
    wait_drain("t6_drain");
    chk("t6_err", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
